// File: rtl/usr_pkg.sv
// Shared constants and types for the universal shift register: mode encodings,
// transfer FSM states and serial-direction flags.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } xfer_state_e;

  // Direction selects which end of the register drives serial_out.
  localparam logic RIGHT = 1'b0;
  localparam logic LEFT  = 1'b1;

endpackage

// File: rtl/usr_xfer_ctrl.sv
// Transfer sequencer: accepts a start pulse in IDLE, runs WIDTH shift cycles,
// then pulses done. Drives load/shift strobes into the datapath.
module usr_xfer_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load_en,
  output logic shift_en
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  xfer_state_e      state;
  logic [CNT_W-1:0] cnt;

  assign load_en  = (state == IDLE) && start;
  assign shift_en = (state == XFER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= XFER;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        XFER: begin
          // The edge seeing CNT_LAST performs the final shift; the counter holds.
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised parallel/serial register with mode-selected shift, rotate and
// clear, plus a self-timed full-duplex serial transfer.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  logic dir_q;
  logic load_en;
  logic shift_en;

  usr_xfer_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .load_en  (load_en),
    .shift_en (shift_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      dir_q    <= RIGHT;
    end else if (load_en) begin
      data_out <= data_in;
      dir_q    <= RIGHT;
    end else if (shift_en) begin
      data_out <= {serial_in, data_out[WIDTH-1:1]};
    end else begin
      // Mode operations only reach here in IDLE with no start request.
      case (mode)
        MODE_LOAD: data_out <= data_in;
        MODE_SHL: begin
          data_out <= {data_out[WIDTH-2:0], serial_in};
          dir_q    <= LEFT;
        end
        MODE_SHR: begin
          data_out <= {serial_in, data_out[WIDTH-1:1]};
          dir_q    <= RIGHT;
        end
        MODE_ROL: begin
          data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]};
          dir_q    <= LEFT;
        end
        MODE_ROR: begin
          data_out <= {data_out[0], data_out[WIDTH-1:1]};
          dir_q    <= RIGHT;
        end
        MODE_CLR: data_out <= '0;
        default:  data_out <= data_out;
      endcase
    end
  end

  assign serial_out = (dir_q == LEFT) ? data_out[WIDTH-1] : data_out[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8) using an expectation
// queue filled as stimulus is driven and drained after each clock edge.
module tb_universal_shift_register;
  import usr_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic       serial_in;
  logic       start;
  logic [7:0] data_out;
  logic       serial_out;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       chk_data;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       sout;
  } exp_t;

  exp_t exp_q[$];

  universal_shift_register #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .data_in    (data_in),
    .serial_in  (serial_in),
    .start      (start),
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic chk_data, input logic [7:0] d,
                          input logic b, input logic dn, input logic so);
    exp_t e;
    e.tag = tag; e.chk_data = chk_data; e.data = d;
    e.busy = b; e.done = dn; e.sout = so;
    exp_q.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later and retire the oldest expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries, required 1");
    end else begin
      e = exp_q.pop_front();
      if (e.chk_data) check({e.tag, "_data"}, data_out, e.data);
      check({e.tag, "_busy"}, {7'd0, busy}, {7'd0, e.busy});
      check({e.tag, "_done"}, {7'd0, done}, {7'd0, e.done});
      check({e.tag, "_sout"}, {7'd0, serial_out}, {7'd0, e.sout});
    end
  endtask

  task automatic op(input string tag, input logic [2:0] m, input logic [7:0] d,
                    input logic si, input logic [7:0] exp_d, input logic exp_so);
    mode = m; data_in = d; serial_in = si; start = 1'b0;
    push_exp(tag, 1'b1, exp_d, 1'b0, 1'b0, exp_so);
    step();
  endtask

  // Full transfer; glitch selects a busy cycle in which start/mode/data_in are disturbed.
  task automatic run_xfer(input string tag, input logic [7:0] word, input logic [7:0] sin,
                          input int glitch, input logic [2:0] start_mode);
    logic [7:0] model;
    mode = start_mode; data_in = word; serial_in = 1'b0; start = 1'b1;
    model = word;
    push_exp({tag, "_start"}, 1'b1, model, 1'b1, 1'b0, word[0]);
    step();
    for (int k = 1; k <= 8; k++) begin
      start = 1'b0; mode = MODE_HOLD; data_in = word;
      if (k == glitch) begin
        start = 1'b1; data_in = 8'hFF; mode = MODE_CLR;
      end
      serial_in = sin[k-1];
      model = {sin[k-1], model[7:1]};
      push_exp($sformatf("%s_e%0d", tag, k), 1'b1, model, (k < 8), (k == 8),
               (k < 8) ? word[k] : model[0]);
      step();
    end
    start = 1'b0; mode = MODE_HOLD; serial_in = 1'b0;
    push_exp({tag, "_after"}, 1'b1, model, 1'b0, 1'b0, model[0]);
    step();
  endtask

  initial begin
    reset = 1'b0; mode = MODE_HOLD; data_in = 8'h00; serial_in = 1'b0; start = 1'b0;
    #3;
    check("por_data", data_out, 8'h00);
    check("por_busy", {7'd0, busy}, 8'h00);
    check("por_done", {7'd0, done}, 8'h00);
    check("por_sout", {7'd0, serial_out}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Mode operations
    op("load81",  MODE_LOAD, 8'h81, 1'b0, 8'h81, 1'b1);
    op("shl",     MODE_SHL,  8'h00, 1'b1, 8'h03, 1'b0);
    op("reload",  MODE_LOAD, 8'h81, 1'b0, 8'h81, 1'b1);
    op("ror",     MODE_ROR,  8'h00, 1'b1, 8'hC0, 1'b0);
    op("clr",     MODE_CLR,  8'h00, 1'b1, 8'h00, 1'b0);
    op("load5a",  MODE_LOAD, 8'h5A, 1'b0, 8'h5A, 1'b0);
    op("rsvd",    3'b111,    8'hFF, 1'b1, 8'h5A, 1'b0);
    op("hold",    MODE_HOLD, 8'hFF, 1'b1, 8'h5A, 1'b0);
    op("shr",     MODE_SHR,  8'h00, 1'b1, 8'hAD, 1'b1);
    op("rol",     MODE_ROL,  8'h00, 1'b0, 8'h5B, 1'b0);
    op("load5a2", MODE_LOAD, 8'h5A, 1'b0, 8'h5A, 1'b0);
    mode = MODE_HOLD;

    // Asynchronous reset mid-cycle, observed before the next edge
    #2 reset = 1'b0;
    #1;
    check("arst_data", data_out, 8'h00);
    check("arst_busy", {7'd0, busy}, 8'h00);
    check("arst_done", {7'd0, done}, 8'h00);
    check("arst_sout", {7'd0, serial_out}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Basic transfer
    run_xfer("xfer", 8'hA5, 8'b0100_1101, 0, MODE_HOLD);
    check("xfer_final", data_out, 8'h4D);

    // Transfer with start/mode/data_in disturbed while busy
    run_xfer("busyin", 8'hA5, 8'b0100_1101, 3, MODE_HOLD);
    check("busyin_final", data_out, 8'h4D);

    // Abort in the 4th busy cycle
    mode = MODE_HOLD; data_in = 8'hA5; serial_in = 1'b1; start = 1'b1;
    push_exp("abort_start", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
    step();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push_exp($sformatf("abort_e%0d", k), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0 ^ (k == 2));
      step();
    end
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {7'd0, busy}, 8'h00);
    check("abort_data", data_out, 8'h00);
    for (int k = 0; k < 9; k++) begin
      push_exp($sformatf("abort_hold%0d", k), 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
    end
    @(negedge clk);
    reset = 1'b1;
    run_xfer("post_abort", 8'h3C, 8'b0100_1101, 0, MODE_HOLD);
    check("post_abort_final", data_out, 8'h4D);

    // start takes priority over mode in IDLE
    run_xfer("prio", 8'h0F, 8'h00, 0, MODE_CLR);
    check("prio_final", data_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
